// File: rtl/ctrl_pkg.sv
// ============================================================================
//  Module      : ctrl_pkg
//  Description : Shared opcodes, control-memory addresses, sequencer state
//                encoding and the branch-resolution helper.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package ctrl_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    localparam logic [6:0] F7_BASE    = 7'b0000000;
    localparam logic [6:0] F7_ALT     = 7'b0100000;
    localparam logic [6:0] F7_MULDIV  = 7'b0000001;

    localparam logic [4:0] ADDR_NOP   = 5'd0;
    localparam logic [4:0] ADDR_ADD   = 5'd1;
    localparam logic [4:0] ADDR_SUB   = 5'd2;
    localparam logic [4:0] ADDR_SLT   = 5'd3;
    localparam logic [4:0] ADDR_SLTU  = 5'd4;
    localparam logic [4:0] ADDR_XOR   = 5'd5;
    localparam logic [4:0] ADDR_OR    = 5'd6;
    localparam logic [4:0] ADDR_AND   = 5'd7;
    localparam logic [4:0] ADDR_SLL   = 5'd8;
    localparam logic [4:0] ADDR_SRL   = 5'd9;
    localparam logic [4:0] ADDR_SRA   = 5'd10;
    localparam logic [4:0] ADDR_ADDI  = 5'd11;
    localparam logic [4:0] ADDR_SLTI  = 5'd12;
    localparam logic [4:0] ADDR_SLTIU = 5'd13;
    localparam logic [4:0] ADDR_XORI  = 5'd14;
    localparam logic [4:0] ADDR_ORI   = 5'd15;
    localparam logic [4:0] ADDR_ANDI  = 5'd16;
    localparam logic [4:0] ADDR_SLLI  = 5'd17;
    localparam logic [4:0] ADDR_SRLI  = 5'd18;
    localparam logic [4:0] ADDR_SRAI  = 5'd19;
    localparam logic [4:0] ADDR_LOAD  = 5'd20;
    localparam logic [4:0] ADDR_STORE = 5'd21;
    localparam logic [4:0] ADDR_BR_NT = 5'd22;
    localparam logic [4:0] ADDR_BR_T  = 5'd23;
    localparam logic [4:0] ADDR_JALR  = 5'd24;
    localparam logic [4:0] ADDR_MUL   = 5'd25;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        EXEC     = 3'd1,
        BR_EVAL  = 3'd2,
        BR_RES   = 3'd3,
        MUL_WAIT = 3'd4
    } state_t;

    function automatic logic br_taken(input logic [2:0] f3, input logic eq,
                                      input logic lt, input logic ltu);
        logic t;
        case (f3)
            3'b000:  t = eq;
            3'b001:  t = !eq;
            3'b100:  t = lt;
            3'b101:  t = !lt;
            3'b110:  t = ltu;
            3'b111:  t = !ltu;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

endpackage

`default_nettype wire

// File: rtl/ctrl_addr_decode.sv
// ============================================================================
//  Module      : ctrl_addr_decode
//  Description : Combinational RV32I+M decode of opcode/funct3/funct7 into a
//                control-memory address plus branch/mul/illegal flags.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_addr_decode
    import ctrl_pkg::*;
(
    input  logic [31:0] instr_i,
    output logic [4:0]  addr_o,
    output logic        is_branch_o,
    output logic        is_mul_o,
    output logic        illegal_o
);

    logic [6:0] opc;
    logic [2:0] f3;
    logic [6:0] f7;
    logic       unused_fields;

    assign opc = instr_i[6:0];
    assign f3  = instr_i[14:12];
    assign f7  = instr_i[31:25];
    assign unused_fields = ^{instr_i[24:15], instr_i[11:7]};

    always_comb begin
        addr_o      = ADDR_NOP;
        is_branch_o = 1'b0;
        is_mul_o    = 1'b0;
        illegal_o   = 1'b0;
        case (opc)
            OPC_OP: begin
                if (f7 == F7_BASE) begin
                    case (f3)
                        3'b000:  addr_o = ADDR_ADD;
                        3'b001:  addr_o = ADDR_SLL;
                        3'b010:  addr_o = ADDR_SLT;
                        3'b011:  addr_o = ADDR_SLTU;
                        3'b100:  addr_o = ADDR_XOR;
                        3'b101:  addr_o = ADDR_SRL;
                        3'b110:  addr_o = ADDR_OR;
                        default: addr_o = ADDR_AND;
                    endcase
                end else if (f7 == F7_ALT && f3 == 3'b000) begin
                    addr_o = ADDR_SUB;
                end else if (f7 == F7_ALT && f3 == 3'b101) begin
                    addr_o = ADDR_SRA;
                end else if (f7 == F7_MULDIV && f3 == 3'b000) begin
                    addr_o   = ADDR_MUL;
                    is_mul_o = 1'b1;
                end else begin
                    illegal_o = 1'b1;
                end
            end
            OPC_OP_IMM: begin
                case (f3)
                    3'b000: addr_o = ADDR_ADDI;
                    3'b010: addr_o = ADDR_SLTI;
                    3'b011: addr_o = ADDR_SLTIU;
                    3'b100: addr_o = ADDR_XORI;
                    3'b110: addr_o = ADDR_ORI;
                    3'b111: addr_o = ADDR_ANDI;
                    3'b001: begin
                        if (f7 == F7_BASE) addr_o = ADDR_SLLI;
                        else               illegal_o = 1'b1;
                    end
                    default: begin
                        // 101: shift kind is selected by imm[11:5]
                        if (f7 == F7_BASE)     addr_o = ADDR_SRLI;
                        else if (f7 == F7_ALT) addr_o = ADDR_SRAI;
                        else                   illegal_o = 1'b1;
                    end
                endcase
            end
            OPC_LOAD:  addr_o = ADDR_LOAD;
            OPC_STORE: addr_o = ADDR_STORE;
            OPC_JALR:  addr_o = ADDR_JALR;
            OPC_BRANCH: begin
                if (f3 == 3'b010 || f3 == 3'b011) begin
                    illegal_o = 1'b1;
                end else begin
                    addr_o      = ADDR_BR_NT;
                    is_branch_o = 1'b1;
                end
            end
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/ctrl_addr_sequencer.sv
// ============================================================================
//  Module      : ctrl_addr_sequencer
//  Description : Microsequencer producing the registered control-memory
//                address for single-cycle, branch and multi-cycle MUL ops.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module ctrl_addr_sequencer
    import ctrl_pkg::*;
#(
    parameter int MUL_MAX_CYCLES = 32
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        instr_valid,
    input  logic [31:0] instr,
    output logic        instr_ready,
    input  logic        br_eq,
    input  logic        br_lt,
    input  logic        br_ltu,
    input  logic        mul_done,
    output logic [4:0]  ctrl_addr,
    output logic        busy,
    output logic        illegal_instr,
    output logic        mul_timeout
);

    localparam int              CNT_W    = (MUL_MAX_CYCLES > 1) ? $clog2(MUL_MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_MAX_CYCLES - 1);

    state_t           state_q, state_d;
    logic [4:0]       addr_q, addr_d;
    logic [2:0]       f3_q, f3_d;
    logic             taken_q, taken_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             illegal_q, illegal_d;
    logic             timeout_q, timeout_d;

    logic [4:0] dec_addr;
    logic       dec_branch;
    logic       dec_mul;
    logic       dec_illegal;
    logic       accept;

    ctrl_addr_decode u_decode (
        .instr_i     (instr),
        .addr_o      (dec_addr),
        .is_branch_o (dec_branch),
        .is_mul_o    (dec_mul),
        .illegal_o   (dec_illegal)
    );

    assign instr_ready   = (state_q == IDLE) || (state_q == EXEC) || (state_q == BR_RES);
    assign busy          = (state_q != IDLE);
    assign accept        = instr_valid && instr_ready;
    assign ctrl_addr     = addr_q;
    assign illegal_instr = illegal_q;
    assign mul_timeout   = timeout_q;

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        f3_d      = f3_q;
        taken_d   = taken_q;
        cnt_d     = cnt_q;
        illegal_d = 1'b0;
        timeout_d = 1'b0;
        case (state_q)
            BR_EVAL: begin
                taken_d = br_taken(f3_q, br_eq, br_lt, br_ltu);
                addr_d  = taken_d ? ADDR_BR_T : ADDR_BR_NT;
                state_d = BR_RES;
            end
            MUL_WAIT: begin
                // mul_done takes priority over an expiring counter
                if (mul_done) begin
                    state_d = IDLE;
                    addr_d  = ADDR_NOP;
                end else if (cnt_q == CNT_LAST) begin
                    state_d   = IDLE;
                    addr_d    = ADDR_NOP;
                    timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                if (accept) begin
                    if (dec_illegal) begin
                        state_d   = IDLE;
                        addr_d    = ADDR_NOP;
                        illegal_d = 1'b1;
                    end else if (dec_branch) begin
                        state_d = BR_EVAL;
                        addr_d  = dec_addr;
                        f3_d    = instr[14:12];
                    end else if (dec_mul) begin
                        state_d = MUL_WAIT;
                        addr_d  = dec_addr;
                        cnt_d   = '0;
                    end else begin
                        state_d = EXEC;
                        addr_d  = dec_addr;
                    end
                end else begin
                    state_d = IDLE;
                    addr_d  = ADDR_NOP;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            addr_q    <= ADDR_NOP;
            f3_q      <= 3'b000;
            taken_q   <= 1'b0;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            f3_q      <= f3_d;
            taken_q   <= taken_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            timeout_q <= timeout_d;
        end
    end

endmodule

`default_nettype wire

// File: doc/ctrl_addr_sequencer.md
# ctrl_addr_sequencer

- Microsequencer in front of the control-memory ROM.
- Accepts a fetched RV32I+M instruction over a valid/ready handshake and decodes opcode/funct3/funct7 into the 5-bit control-memory address.
- Sequences that address over one or more cycles:
  - single cycle for ALU, load, store and jalr;
  - two-phase evaluate/resolve for branches;
  - held for multi-cycle multiplies.
- It is the producer of `controlMemAddr`; the control-signal ROM consumes it.

## Interface
- `MUL_MAX_CYCLES`, default 32: cycles `ctrl_addr` is held at the MUL address before the multiply is declared hung.
- `clk` input 1: system clock, all state on rising edge.
- `reset` input 1: synchronous, active-high.
- `instr_valid` input 1: fetch stage presents `instr`.
- `instr` input 32: raw instruction word.
- `instr_ready` output 1: sequencer can accept; transfer occurs on a `clk` edge with valid and ready both high.
- `br_eq` input 1: comparator result rs1 == rs2.
- `br_lt` input 1: comparator result rs1 < rs2, signed.
- `br_ltu` input 1: comparator result rs1 < rs2, unsigned.
- `mul_done` input 1: multiplier result ready.
- `ctrl_addr` output 5: control-memory address, registered.
- `busy` output 1: state ≠ IDLE.
- `illegal_instr` output 1: one-cycle pulse, accepted instruction undecodable.
- `mul_timeout` output 1: one-cycle pulse, MUL exceeded `MUL_MAX_CYCLES`.

## Operation
- Reset values:
  - state IDLE;
  - `ctrl_addr` = 0 (NOP, all control signals zero);
  - `instr_ready` = 1;
  - `busy`, `illegal_instr`, `mul_timeout` = 0;
  - MUL cycle counter = 0.
- Decode map:
  - **R-type (0110011), funct7=0000000:** add 1, sll 8, slt 3, sltu 4, xor 5, srl 9, or 6, and 7.
  - **R-type (0110011), funct7=0100000:** sub 2 (funct3 000), sra 10 (funct3 101).
  - **R-type (0110011), funct7=0000001:** funct3 000 → mul 25; any other funct3 is illegal.
  - **OP-IMM (0010011):** addi 11, slti 12, sltiu 13, xori 14, ori 15, andi 16, slli 17.
  - **OP-IMM (0010011), shifts:** srli 18 (imm[11:5]=0000000), srai 19 (imm[11:5]=0100000).
  - **Other opcodes:** LOAD (0000011) 20; STORE (0100011) 21; JALR (1100111) 24.
  - **BRANCH (1100011):** 22 or 23, per the branch table below.
  - **Illegal:** everything else, including branch funct3 010/011 and unlisted funct7 values.
- States:
  - **IDLE:** `ctrl_addr`=0, ready=1. On accept:
    - single-cycle op → EXEC;
    - branch → BR_EVAL;
    - mul → MUL_WAIT (counter cleared);
    - illegal → stay IDLE, pulse `illegal_instr` next cycle, `ctrl_addr` stays 0.
  - **EXEC:** `ctrl_addr`=decoded address for exactly one cycle, ready=1.
    - On accept in the same cycle, go to the next instruction's state (back-to-back issue).
    - Otherwise go to IDLE.
  - **BR_EVAL:** `ctrl_addr`=22, ready=0.
    - Flags are sampled at the end of this cycle only.
    - Go to BR_RES with the taken bit stored.
  - **BR_RES:** `ctrl_addr`=23 if taken, else 22. ready=1; accept rules as EXEC.
  - **MUL_WAIT:** `ctrl_addr`=25, ready=0, counter increments each cycle.
    - `mul_done`=1 → IDLE.
    - Counter reaches `MUL_MAX_CYCLES`−1 without `mul_done` → IDLE and pulse `mul_timeout`.
- Branch taken rule, by funct3:
  - 000 beq: taken if `br_eq`.
  - 001 bne: taken if `!br_eq`.
  - 100 blt: taken if `br_lt`.
  - 101 bge: taken if `!br_lt`.
  - 110 bltu: taken if `br_ltu`.
  - 111 bgeu: taken if `!br_ltu`.
- Boundary rules:
  - `mul_done` outside MUL_WAIT is ignored.
  - Branch flags outside BR_EVAL are ignored.
  - `mul_done` and timeout in the same cycle: `mul_done` wins, no timeout pulse.
  - `instr` is captured at accept; later changes on `instr` have no effect.
  - An illegal instruction accepted in EXEC/BR_RES returns to IDLE with an `illegal_instr` pulse.
  - Reset mid-operation: next cycle is IDLE, `ctrl_addr`=0, captured instruction and stored taken bit discarded, no pulses.

## Timing
- Latency, accept at edge N:
  - single-cycle op: `ctrl_addr` valid from N+1 for one cycle.
  - branch: 22 at N+1, resolved 22/23 at N+2.
  - mul: 25 from N+1 through the cycle in which `mul_done` is seen.
- Throughput:
  - one single-cycle op per cycle when `instr_valid` is held high;
  - a branch occupies 2 cycles;
  - a mul occupies k+1 cycles, where `mul_done` arrives k cycles after entry.
- `illegal_instr` and `mul_timeout` are registered and high for exactly one cycle.
- `instr_ready` and `busy` are combinational from state.

## Structure
- Package `ctrl_pkg`:
  - opcode constants;
  - control-address constants ADDR_NOP=0 … ADDR_MUL=25, plus ADDR_BR_NT=22 and ADDR_BR_T=23;
  - state enum {IDLE, EXEC, BR_EVAL, BR_RES, MUL_WAIT}.
- Sub-module `ctrl_addr_decode`: purely combinational. Maps `instr` to {addr, is_branch, is_mul, illegal}.
- The sequencer holds the FSM, the capture register, the taken bit and the MUL counter.

## Test plan
- Reset, then check all outputs at reset value. Issue back-to-back add (0x002081B3) then sub (0x402081B3) with valid held → `ctrl_addr` 1 then 2 on consecutive cycles, ready stays 1.
- bne (funct3 001), `br_eq`=0 in BR_EVAL → `ctrl_addr` 22 then 23. Repeat bgeu with `br_ltu`=1 → 22 then 22.
- mul (0x022081B3), `mul_done` after 5 cycles → `ctrl_addr`=25 for 6 cycles, then 0; `mul_done` pulsed in IDLE is ignored.
- mul with `mul_done` never asserted and `MUL_MAX_CYCLES`=8 → 25 for 8 cycles, `mul_timeout` pulse, return to IDLE.
- Opcode 0x7F, and branch funct3 010 → `illegal_instr` one-cycle pulse, `ctrl_addr` remains 0.
- `reset` asserted during MUL_WAIT and during BR_EVAL → next cycle IDLE, `ctrl_addr`=0, no pulses. The following addi (0x00108093) yields 11.
